// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port, multi-cycle data memory
// between the fetch port (I, read-only) and the memory-access port (D, read/write).
// One access runs at a time: grant in IDLE, WAIT_CYCLES cycles of ACCESS, then a
// one-cycle DONE where the owner's ready pulses.
module mem_port_arbiter #(
  parameter int DATA_LEN         = 32,
  parameter int ADDRESS_LEN      = 32,
  parameter int MEM_ADDRESS_LINE = 64,
  parameter int WAIT_CYCLES      = 4,
  localparam int MAW             = $clog2(MEM_ADDRESS_LINE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req,
  input  logic [ADDRESS_LEN-1:0] i_addr,
  output logic [DATA_LEN-1:0]    i_rdata,
  output logic                   i_ready,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [ADDRESS_LEN-1:0] d_addr,
  input  logic [DATA_LEN-1:0]    d_wdata,
  output logic [DATA_LEN-1:0]    d_rdata,
  output logic                   d_ready,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [MAW-1:0]         mem_addr,
  output logic [DATA_LEN-1:0]    mem_wdata,
  input  logic [DATA_LEN-1:0]    mem_rdata,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t              state, state_n;
  logic [3:0]          cnt;
  logic                owner;
  logic                last_grant;
  logic                we_q;
  logic [MAW-1:0]      addr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic                any_req;
  logic                grant_d;

  // D wins when it is alone, or on a tie when I was served last.
  assign any_req = i_req | d_req;
  assign grant_d = d_req & (~i_req | (last_grant == PORT_I));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic: IDLE -> ACCESS -> DONE -> IDLE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control registers: grant bookkeeping, cycle counter and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      owner      <= PORT_I;
      last_grant <= PORT_I;
      we_q       <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= grant_d;
            we_q  <= grant_d & d_we;
            cnt   <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!we_q) begin
              if (owner == PORT_D) d_rdata <= mem_rdata;
              else                 i_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    last_grant <= owner;
        default: ;
      endcase
    end
  end

  // Granted address and write data; only observed while ACCESS, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      addr_q  <= grant_d ? d_addr[MAW+1:2] : i_addr[MAW+1:2];
      wdata_q <= d_wdata;
    end
  end

  // Memory strobes are gated by ACCESS so every output is quiet outside an access;
  // the write strobe fires only in the first ACCESS cycle (counter still at its load value).
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & we_q & (cnt == CNT_INIT);
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign i_ready   = (state == DONE) & (owner == PORT_I);
  assign d_ready   = (state == DONE) & (owner == PORT_D);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory.
module tb_mem_port_arbiter;

  localparam int DL  = 32;
  localparam int AL  = 32;
  localparam int MAW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AL-1:0] i_addr = '0;
  logic [DL-1:0] i_rdata;
  logic          i_ready;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AL-1:0] d_addr = '0;
  logic [DL-1:0] d_wdata = '0;
  logic [DL-1:0] d_rdata;
  logic          d_ready;
  logic          mem_en;
  logic          mem_we;
  logic [MAW-1:0] mem_addr;
  logic [DL-1:0] mem_wdata;
  logic [DL-1:0] mem_rdata;
  logic          busy;

  logic [DL-1:0]  mem [64];
  logic           pl_we = 1'b0;
  logic [MAW-1:0] pl_addr = '0;
  logic [DL-1:0]  pl_data = '0;

  int vecs = 0;
  int errs = 0;
  int en_cnt = 0, we_cnt = 0, ir_cnt = 0, dr_cnt = 0, both_cnt = 0;

  mem_port_arbiter #(
    .DATA_LEN(DL), .ADDRESS_LEN(AL), .MEM_ADDRESS_LINE(64), .WAIT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the clock edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_en) en_cnt++;
    if (mem_we) we_cnt++;
    if (i_ready) ir_cnt++;
    if (d_ready) dr_cnt++;
    if (i_ready && d_ready) both_cnt++;
  end

  task automatic preload(input logic [MAW-1:0] a, input logic [DL-1:0] d);
    @(negedge clk); pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk); pl_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  // Waits up to 20 cycles for the selected ready; returns at the negedge it is seen.
  task automatic wait_ready(input bit port_d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (port_d ? d_ready : i_ready) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    vecs++; if ({mem_en, mem_we, i_ready, d_ready, busy} !== 5'b0) begin errs++;
      $display("FAIL reset_ctrl: got %b expected 00000", {mem_en, mem_we, i_ready, d_ready, busy}); end
    vecs++; if (i_rdata !== '0) begin errs++; $display("FAIL reset_i_rdata: got %h expected 0", i_rdata); end
    vecs++; if (d_rdata !== '0) begin errs++; $display("FAIL reset_d_rdata: got %h expected 0", d_rdata); end
    vecs++; if (mem_addr !== '0) begin errs++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    vecs++; if (mem_wdata !== '0) begin errs++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    int e0;
    preload(6'd2, 32'hE3A0_0005);
    @(negedge clk); i_req = 1'b1; i_addr = 32'd8;
    #1 e0 = en_cnt;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vecs++; if (mem_en !== 1'b1 || mem_addr !== 6'd2 || busy !== 1'b1 || i_ready !== 1'b0) begin errs++;
        $display("FAIL t1_access_c%0d: got en=%b addr=%0d busy=%b rdy=%b expected 1 2 1 0", k, mem_en, mem_addr, busy, i_ready); end
    end
    @(negedge clk);
    vecs++; if (i_ready !== 1'b1) begin errs++; $display("FAIL t1_i_ready: got %b expected 1", i_ready); end
    vecs++; if (i_rdata !== 32'hE3A0_0005) begin errs++; $display("FAIL t1_i_rdata: got %h expected e3a00005", i_rdata); end
    vecs++; if (mem_en !== 1'b0 || busy !== 1'b1 || d_ready !== 1'b0) begin errs++;
      $display("FAIL t1_done: got en=%b busy=%b d_ready=%b expected 0 1 0", mem_en, busy, d_ready); end
    i_req = 1'b0;
    @(negedge clk); #1;
    vecs++; if (i_ready !== 1'b0 || busy !== 1'b0) begin errs++;
      $display("FAIL t1_idle: got rdy=%b busy=%b expected 0 0", i_ready, busy); end
    vecs++; if (en_cnt - e0 !== 4) begin errs++; $display("FAIL t1_en_cycles: got %0d expected 4", en_cnt - e0); end
  endtask

  task automatic test_write_read();
    bit ok;
    int w0;
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'd8;
    wait_ready(1'b1, ok); d_req = 1'b0;
    vecs++; if (!ok || d_rdata !== 32'hE3A0_0005) begin errs++;
      $display("FAIL t2_pre_read: got ok=%b data=%h expected 1 e3a00005", ok, d_rdata); end
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'd12; d_wdata = 32'hDEAD_BEEF;
    #1 w0 = we_cnt;
    wait_ready(1'b1, ok); d_req = 1'b0; d_we = 1'b0;
    vecs++; if (!ok) begin errs++; $display("FAIL t2_write_ready: got 0 expected 1"); end
    @(negedge clk); #1;
    vecs++; if (we_cnt - w0 !== 1) begin errs++; $display("FAIL t2_we_cycles: got %0d expected 1", we_cnt - w0); end
    vecs++; if (d_rdata !== 32'hE3A0_0005) begin errs++; $display("FAIL t2_rdata_kept: got %h expected e3a00005", d_rdata); end
    vecs++; if (mem[3] !== 32'hDEAD_BEEF) begin errs++; $display("FAIL t2_mem3: got %h expected deadbeef", mem[3]); end
    @(negedge clk); d_req = 1'b1; d_addr = 32'd12;
    wait_ready(1'b1, ok); d_req = 1'b0;
    vecs++; if (!ok || d_rdata !== 32'hDEAD_BEEF) begin errs++;
      $display("FAIL t2_read_back: got ok=%b data=%h expected 1 deadbeef", ok, d_rdata); end
  endtask

  task automatic test_back_to_back();
    int n;
    int b0;
    bit order [4];
    int at [4];
    do_reset();
    @(negedge clk); i_req = 1'b1; i_addr = 32'd8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd12;
    #1 b0 = both_cnt;
    n = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk);
      if (i_ready || d_ready) begin order[n] = d_ready; at[n] = c; n++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    vecs++; if (n !== 4) begin errs++; $display("FAIL t3_pulses: got %0d expected 4", n); end
    else begin
      vecs++; if ({order[0], order[1], order[2], order[3]} !== 4'b1010) begin errs++;
        $display("FAIL t3_order: got %b expected 1010 (D,I,D,I)", {order[0], order[1], order[2], order[3]}); end
      vecs++; if (at[0] !== 5 || at[1] !== 11 || at[2] !== 17 || at[3] !== 23) begin errs++;
        $display("FAIL t3_spacing: got %0d %0d %0d %0d expected 5 11 17 23", at[0], at[1], at[2], at[3]); end
    end
    #1;
    vecs++; if (both_cnt - b0 !== 0) begin errs++; $display("FAIL t3_both_ready: got %0d expected 0", both_cnt - b0); end
    vecs++; if (i_rdata !== 32'hE3A0_0005 || d_rdata !== 32'hDEAD_BEEF) begin errs++;
      $display("FAIL t3_rdata: got %h %h expected e3a00005 deadbeef", i_rdata, d_rdata); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int w0, r0;
    do_reset();
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'd16; d_wdata = 32'h1234_5678;
    #1 begin w0 = we_cnt; r0 = dr_cnt; end
    @(negedge clk);
    @(negedge clk);
    vecs++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errs++;
      $display("FAIL t4_second_access: got en=%b we=%b expected 1 0", mem_en, mem_we); end
    rst = 1'b1;
    @(negedge clk);
    vecs++; if ({mem_en, mem_we, busy, d_ready} !== 4'b0) begin errs++;
      $display("FAIL t4_abort: got en/we/busy/rdy=%b expected 0000", {mem_en, mem_we, busy, d_ready}); end
    rst = 1'b0;
    wait_ready(1'b1, ok); d_req = 1'b0; d_we = 1'b0;
    vecs++; if (!ok) begin errs++; $display("FAIL t4_restart_ready: got 0 expected 1"); end
    @(negedge clk); #1;
    vecs++; if (we_cnt - w0 !== 2) begin errs++; $display("FAIL t4_we_pulses: got %0d expected 2", we_cnt - w0); end
    vecs++; if (dr_cnt - r0 !== 1) begin errs++; $display("FAIL t4_ready_pulses: got %0d expected 1", dr_cnt - r0); end
    vecs++; if (mem[4] !== 32'h1234_5678) begin errs++; $display("FAIL t4_mem4: got %h expected 12345678", mem[4]); end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    preload(6'd1, 32'hA5A5_0101);
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0107;
    @(negedge clk);
    vecs++; if (mem_addr !== 6'd1) begin errs++; $display("FAIL t5_mem_addr: got %0d expected 1", mem_addr); end
    wait_ready(1'b1, ok); d_req = 1'b0;
    vecs++; if (!ok || d_rdata !== 32'hA5A5_0101) begin errs++;
      $display("FAIL t5_rdata: got ok=%b data=%h expected 1 a5a50101", ok, d_rdata); end
  endtask

  task automatic test_drop_req();
    bit ok;
    int r0;
    @(negedge clk); i_req = 1'b1; i_addr = 32'd4;
    #1 r0 = ir_cnt;
    @(negedge clk);
    @(negedge clk); i_req = 1'b0; i_addr = 32'h20;
    wait_ready(1'b0, ok);
    vecs++; if (!ok || i_rdata !== 32'hA5A5_0101) begin errs++;
      $display("FAIL t6_complete: got ok=%b data=%h expected 1 a5a50101", ok, i_rdata); end
    repeat (3) @(negedge clk);
    #1;
    vecs++; if (busy !== 1'b0 || mem_en !== 1'b0) begin errs++;
      $display("FAIL t6_idle: got busy=%b en=%b expected 0 0", busy, mem_en); end
    vecs++; if (ir_cnt - r0 !== 1) begin errs++; $display("FAIL t6_ready_pulses: got %0d expected 1", ir_cnt - r0); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_back_to_back();
    test_mid_reset();
    test_addr_wrap();
    test_drop_req();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
